// File: rtl/spi_mem_ctrl.sv
// Memory-side responder: turns each MEM_READ/MEM_WRITE request into one 40-bit SPI mode-0 frame
// (cmd, 24-bit address, data) to the flash (addr_sel=PC) or the RAM (addr_sel=MAR).
//   state    | meaning
//   IDLE     | waiting for a request; inputs are latched when one arrives
//   SHIFT    | frame on the wire, CS low, sclk toggling
//   FINISH   | completion cycle of a rejected flash write (done + wr_err)
//   COOLDOWN | one CS-high cycle that swallows the still-asserted request
module spi_mem_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int CLK_DIV        = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                mem_ctrl_op,
    input  logic                      addr_sel,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
    output logic [DATA_BUS_WIDTH-1:0] mem_data_out,
    output logic                      mem_op_done,
    output logic                      wr_err,
    output logic                      busy,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_cs_flash_n,
    output logic                      spi_cs_ram_n
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        FINISH   = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam int             DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    state_e                    state_q;
    logic [DIV_W-1:0]          div_cnt_q;
    logic [5:0]                bit_cnt_q;
    logic [38:0]               shreg_q;
    logic [DATA_BUS_WIDTH-1:0] rx_q;
    logic [DATA_BUS_WIDTH-1:0] mem_data_q;
    logic                      is_read_q;
    logic                      done_q;
    logic                      wr_err_q;
    logic                      busy_q;
    logic                      sclk_q;
    logic                      mosi_q;
    logic                      cs_flash_n_q;
    logic                      cs_ram_n_q;
    logic [39:0]               frame_d;

    always_comb begin
        frame_d = {(mem_ctrl_op == MEM_WRITE) ? 8'h02 : 8'h03,
                   24'(addr),
                   (mem_ctrl_op == MEM_WRITE) ? 8'(bus_data_in) : 8'h00};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_q         <= '0;
            mem_data_q   <= '0;
            is_read_q    <= 1'b0;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
            busy_q       <= 1'b0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_flash_n_q <= 1'b1;
            cs_ram_n_q   <= 1'b1;
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_ctrl_op == MEM_READ || mem_ctrl_op == MEM_WRITE) begin
                        busy_q    <= 1'b1;
                        is_read_q <= (mem_ctrl_op == MEM_READ);
                        if (mem_ctrl_op == MEM_WRITE && !addr_sel) begin
                            // flash is read-only: reject without touching the bus
                            done_q   <= 1'b1;
                            wr_err_q <= 1'b1;
                            state_q  <= FINISH;
                        end else begin
                            cs_flash_n_q <= addr_sel;
                            cs_ram_n_q   <= ~addr_sel;
                            mosi_q       <= frame_d[39];
                            shreg_q      <= frame_d[38:0];
                            bit_cnt_q    <= 6'd39;
                            div_cnt_q    <= DIV_RELOAD;
                            sclk_q       <= 1'b0;
                            state_q      <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (div_cnt_q != '0) begin
                        div_cnt_q <= div_cnt_q - 1'b1;
                    end else begin
                        div_cnt_q <= DIV_RELOAD;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[DATA_BUS_WIDTH-2:0], spi_miso};
                        end else if (bit_cnt_q == '0) begin
                            sclk_q       <= 1'b0;
                            mosi_q       <= 1'b0;
                            cs_flash_n_q <= 1'b1;
                            cs_ram_n_q   <= 1'b1;
                            done_q       <= 1'b1;
                            if (is_read_q) mem_data_q <= rx_q;
                            state_q      <= COOLDOWN;
                        end else begin
                            sclk_q    <= 1'b0;
                            mosi_q    <= shreg_q[38];
                            shreg_q   <= {shreg_q[37:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_q <= COOLDOWN;
                end
                COOLDOWN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_data_out   = mem_data_q;
    assign mem_op_done    = done_q;
    assign wr_err         = wr_err_q;
    assign busy           = busy_q;
    assign spi_sclk       = sclk_q;
    assign spi_mosi       = mosi_q;
    assign spi_cs_flash_n = cs_flash_n_q;
    assign spi_cs_ram_n   = cs_ram_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Randomized bench for spi_mem_ctrl with behavioural SPI flash/RAM slave models.
module tb_spi_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel, miso, done, werr, busy, sclk, mosi, csf_n, csr_n;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata, rdata;

    logic        rst3, sel3, miso3, done3, werr3, busy3, sclk3, mosi3, csf3_n, csr3_n;
    logic [1:0]  op3;
    logic [15:0] addr3;
    logic [7:0]  wdata3, rdata3;

    spi_mem_ctrl dut (
        .clock(clk), .reset(rst), .mem_ctrl_op(op), .addr_sel(sel), .addr(addr),
        .bus_data_in(wdata), .mem_data_out(rdata), .mem_op_done(done), .wr_err(werr),
        .busy(busy), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso),
        .spi_cs_flash_n(csf_n), .spi_cs_ram_n(csr_n)
    );

    spi_mem_ctrl #(.CLK_DIV(3)) dut3 (
        .clock(clk), .reset(rst3), .mem_ctrl_op(op3), .addr_sel(sel3), .addr(addr3),
        .bus_data_in(wdata3), .mem_data_out(rdata3), .mem_op_done(done3), .wr_err(werr3),
        .busy(busy3), .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_miso(miso3),
        .spi_cs_flash_n(csf3_n), .spi_cs_ram_n(csr3_n)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- SPI slave model for dut ----------------
    typedef struct {
        bit          ram;
        int          nbits;
        logic [39:0] bits;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] flash_mem [0:65535];
    logic [7:0] ram_mem   [0:65535];
    logic [7:0] ref_ram   [0:65535];
    logic [39:0] rx_frame = '0;
    logic [7:0]  rd_byte = '0;
    int          bitcnt = 0;
    bit          act_ram = 1'b0;

    always @(negedge csf_n) begin bitcnt = 0; act_ram = 1'b0; end
    always @(negedge csr_n) begin bitcnt = 0; act_ram = 1'b1; end

    always @(posedge sclk) begin
        if (!csf_n || !csr_n) begin
            rx_frame = {rx_frame[38:0], mosi};
            bitcnt++;
            if (bitcnt == 32)
                rd_byte = act_ram ? ram_mem[rx_frame[15:0]] : flash_mem[rx_frame[15:0]];
        end
    end

    always @(posedge csf_n or posedge csr_n) begin
        if (bitcnt > 0) begin
            frames.push_back('{act_ram, bitcnt, rx_frame});
            if (bitcnt == 40 && act_ram && rx_frame[39:32] == 8'h02)
                ram_mem[rx_frame[23:8]] = rx_frame[7:0];
        end
        bitcnt = 0;
    end

    assign miso = (bitcnt >= 32 && bitcnt < 40) ? rd_byte[3'(39 - bitcnt)] : 1'b0;

    // ---------------- simple pattern slave for dut3 ----------------
    logic [39:0] pat3 = '0;
    logic [39:0] frame3 = '0;
    int          cnt3 = 0;

    always @(negedge csf3_n or negedge csr3_n) cnt3 = 0;
    always @(posedge sclk3) begin
        if (!csf3_n || !csr3_n) begin
            frame3 = {frame3[38:0], mosi3};
            cnt3++;
        end
    end
    assign miso3 = (cnt3 < 40) ? pat3[6'(39 - cnt3)] : 1'b0;

    // ---------------- observation of one request on dut ----------------
    int         o_done_cnt, o_done_cyc, o_werr_cnt, o_werr_cyc;
    int         o_fl_low, o_ram_low, o_busy_last, o_rises;
    logic [7:0] o_data_done;
    logic [7:0] exp_rdata = 8'h00;

    task automatic run_txn(input logic [1:0] o, input logic s, input logic [15:0] a,
                           input logic [7:0] d, input int window, input int release_cyc,
                           input int chg_cyc);
        logic prev;
        @(negedge clk);
        op = o; sel = s; addr = a; wdata = d;
        frames.delete();
        o_done_cnt = 0; o_done_cyc = -1; o_werr_cnt = 0; o_werr_cyc = -1;
        o_fl_low = 0; o_ram_low = 0; o_busy_last = 0; o_rises = 0; o_data_done = 8'hxx;
        prev = sclk;
        @(posedge clk);
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            if (done) begin
                o_done_cnt++;
                if (o_done_cyc < 0) begin o_done_cyc = c; o_data_done = rdata; end
            end
            if (werr) begin o_werr_cnt++; if (o_werr_cyc < 0) o_werr_cyc = c; end
            if (!csf_n) o_fl_low++;
            if (!csr_n) o_ram_low++;
            if (busy) o_busy_last = c;
            if (sclk && !prev) o_rises++;
            prev = sclk;
            if (c == release_cyc) op = 2'b00;
            if (c == chg_cyc) begin addr = 16'hFFFF; wdata = ~d; end
        end
        op = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        op = 2'b00; sel = 1'b0; addr = '0; wdata = '0;
        op3 = 2'b00; sel3 = 1'b0; addr3 = '0; wdata3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (werr !== 1'b0) begin errors++; $display("FAIL reset_werr got=%b exp=0", werr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        checks++; if ({csf_n, csr_n} !== 2'b11) begin errors++; $display("FAIL reset_cs got=%b exp=11", {csf_n, csr_n}); end
        checks++; if ({busy3, csf3_n, csr3_n} !== 3'b011) begin errors++; $display("FAIL reset_dut3 got=%b exp=011", {busy3, csf3_n, csr3_n}); end
        rst = 1'b0; rst3 = 1'b0;
        exp_rdata = 8'h00;
    endtask

    task automatic test_flash_read();
        flash_mem[16'h0012] = 8'hA5;
        run_txn(2'b01, 1'b0, 16'h0012, 8'h77, 100, 82, 40);
        checks++; if (o_done_cyc !== 81) begin errors++; $display("FAIL fread_done_cycle got=%0d exp=81", o_done_cyc); end
        checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL fread_done_count got=%0d exp=1", o_done_cnt); end
        checks++; if (o_fl_low !== 80) begin errors++; $display("FAIL fread_cs_flash_low got=%0d exp=80", o_fl_low); end
        checks++; if (o_ram_low !== 0) begin errors++; $display("FAIL fread_cs_ram_low got=%0d exp=0", o_ram_low); end
        checks++; if (o_rises !== 40) begin errors++; $display("FAIL fread_sclk_rises got=%0d exp=40", o_rises); end
        checks++; if (o_busy_last !== 81) begin errors++; $display("FAIL fread_busy_last got=%0d exp=81", o_busy_last); end
        checks++; if (o_data_done !== 8'hA5) begin errors++; $display("FAIL fread_data got=%h exp=a5", o_data_done); end
        checks++;
        if (frames.size() !== 1) begin
            errors++; $display("FAIL fread_frame_count got=%0d exp=1", frames.size());
        end else if (frames[0].bits !== 40'h03_000012_00 || frames[0].nbits !== 40 || frames[0].ram) begin
            errors++; $display("FAIL fread_frame got=%h/%0d exp=0300001200/40", frames[0].bits, frames[0].nbits);
        end
        exp_rdata = 8'hA5;
    endtask

    task automatic test_ram_write();
        ref_ram[16'h1234] = 8'h5C;
        run_txn(2'b10, 1'b1, 16'h1234, 8'h5C, 100, 82, 0);
        checks++; if (o_done_cyc !== 81) begin errors++; $display("FAIL rwrite_done_cycle got=%0d exp=81", o_done_cyc); end
        checks++; if (o_ram_low !== 80 || o_fl_low !== 0) begin errors++; $display("FAIL rwrite_cs got=%0d/%0d exp=80/0", o_ram_low, o_fl_low); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rwrite_rdata_held got=%h exp=%h", rdata, exp_rdata); end
        checks++; if (ram_mem[16'h1234] !== 8'h5C) begin errors++; $display("FAIL rwrite_stored got=%h exp=5c", ram_mem[16'h1234]); end
        checks++;
        if (frames.size() !== 1) begin
            errors++; $display("FAIL rwrite_frame_count got=%0d exp=1", frames.size());
        end else if (frames[0].bits !== 40'h02_001234_5C || !frames[0].ram) begin
            errors++; $display("FAIL rwrite_frame got=%h exp=020012345c", frames[0].bits);
        end
    endtask

    task automatic test_flash_write_reject();
        run_txn(2'b10, 1'b0, 16'($urandom), 8'($urandom), 20, 2, 0);
        checks++; if (o_done_cyc !== 1 || o_done_cnt !== 1) begin errors++; $display("FAIL fwrite_done got=%0d/%0d exp=1/1", o_done_cyc, o_done_cnt); end
        checks++; if (o_werr_cyc !== 1 || o_werr_cnt !== 1) begin errors++; $display("FAIL fwrite_werr got=%0d/%0d exp=1/1", o_werr_cyc, o_werr_cnt); end
        checks++; if (o_fl_low !== 0 || o_ram_low !== 0) begin errors++; $display("FAIL fwrite_cs got=%0d/%0d exp=0/0", o_fl_low, o_ram_low); end
        checks++; if (o_rises !== 0) begin errors++; $display("FAIL fwrite_sclk got=%0d exp=0", o_rises); end
        checks++; if (o_busy_last !== 2) begin errors++; $display("FAIL fwrite_idle got_busy_last=%0d exp=2", o_busy_last); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL fwrite_rdata got=%h exp=%h", rdata, exp_rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            int          r, exp_done, chg;
            logic [1:0]  o;
            logic        s;
            logic [15:0] a;
            logic [7:0]  d, ev;
            logic [39:0] ef;
            r = $urandom_range(0, 5);
            o = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 4) ? 2'b01 : 2'b10;
            s = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 1) ? 16'(16'h00F0 + $urandom_range(0, 3)) : 16'($urandom);
            d = 8'($urandom);
            chg = $urandom_range(0, 1) ? $urandom_range(2, 78) : 0;
            exp_done = (o == 2'b01 || o == 2'b10) ? ((o == 2'b10 && !s) ? 1 : 81) : 0;
            run_txn(o, s, a, d, 95, exp_done + 1, chg);
            checks++;
            if (exp_done == 0) begin
                if (o_done_cnt !== 0 || frames.size() !== 0 || o_busy_last !== 0) begin
                    errors++; $display("FAIL rnd%0d_nop done=%0d frames=%0d busy=%0d exp=0/0/0", i, o_done_cnt, frames.size(), o_busy_last);
                end
            end else if (exp_done == 1) begin
                if (o_done_cyc !== 1 || o_werr_cnt !== 1 || frames.size() !== 0) begin
                    errors++; $display("FAIL rnd%0d_reject done=%0d werr=%0d frames=%0d exp=1/1/0", i, o_done_cyc, o_werr_cnt, frames.size());
                end
            end else begin
                ef = {(o == 2'b10) ? 8'h02 : 8'h03, 8'h00, a, (o == 2'b10) ? d : 8'h00};
                if (o_done_cyc !== 81 || o_done_cnt !== 1 || o_werr_cnt !== 0 || frames.size() !== 1) begin
                    errors++; $display("FAIL rnd%0d_txn done=%0d/%0d werr=%0d frames=%0d exp=81/1/0/1", i, o_done_cyc, o_done_cnt, o_werr_cnt, frames.size());
                end else if (frames[0].bits !== ef || frames[0].ram !== s) begin
                    errors++; $display("FAIL rnd%0d_frame got=%h exp=%h", i, frames[0].bits, ef);
                end
                if (o == 2'b10) ref_ram[a] = d;
                else exp_rdata = s ? ref_ram[a] : flash_mem[a];
            end
            checks++;
            if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, rdata, exp_rdata); end
            if (o == 2'b10 && s) begin
                checks++;
                if (ram_mem[a] !== ref_ram[a]) begin errors++; $display("FAIL rnd%0d_ramstore got=%h exp=%h", i, ram_mem[a], ref_ram[a]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        @(negedge clk);
        op = 2'b01; sel = 1'b0; addr = 16'($urandom); frames.delete();
        @(posedge clk);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst = 1'b1; op = 2'b00;
        @(negedge clk);
        checks++; if ({csf_n, csr_n, sclk, busy, done} !== 5'b11000) begin errors++; $display("FAIL rstmid_outputs got=%b exp=11000", {csf_n, csr_n, sclk, busy, done}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rdata got=%h exp=00", rdata); end
        rst = 1'b0;
        exp_rdata = 8'h00;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dcnt); end
        checks++;
        if (frames.size() !== 1 || frames[0].nbits !== 11) begin
            errors++; $display("FAIL rstmid_abort_bits frames=%0d exp=1 bits=11", frames.size());
        end
        run_txn(2'b01, 1'b1, 16'h0001, 8'h00, 95, 82, 0);
        exp_rdata = ref_ram[16'h0001];
        checks++; if (o_done_cyc !== 81 || o_data_done !== exp_rdata) begin errors++; $display("FAIL rstmid_followup got=%0d/%h exp=81/%h", o_done_cyc, o_data_done, exp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, a2;
        int dcyc[$];
        int falls[$];
        logic prev;
        a1 = 16'($urandom); a2 = 16'($urandom);
        @(negedge clk);
        op = 2'b01; sel = 1'b1; addr = a1; frames.delete();
        prev = csr_n;
        @(posedge clk);
        for (int c = 1; c <= 180; c++) begin
            @(negedge clk);
            if (done) dcyc.push_back(c);
            if (!csr_n && prev) falls.push_back(c);
            prev = csr_n;
            if (c == 81) begin
                checks++; if (rdata !== ref_ram[a1]) begin errors++; $display("FAIL b2b_data1 got=%h exp=%h", rdata, ref_ram[a1]); end
                addr = a2;
            end
            if (c == 164) op = 2'b00;
        end
        exp_rdata = ref_ram[a2];
        checks++;
        if (dcyc.size() !== 2 || dcyc[0] !== 81 || dcyc[1] !== 163) begin
            errors++; $display("FAIL b2b_done_cycles count=%0d exp=2 at 81,163", dcyc.size());
        end
        checks++;
        if (falls.size() !== 2 || falls[0] !== 1 || falls[1] !== 83) begin
            errors++; $display("FAIL b2b_cs_falls count=%0d exp=2 at 1,83", falls.size());
        end
        checks++;
        if (frames.size() !== 2 || frames[0].bits !== {16'h0300, a1, 8'h00} || frames[1].bits !== {16'h0300, a2, 8'h00}) begin
            errors++; $display("FAIL b2b_frames count=%0d exp=2", frames.size());
        end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL b2b_data2 got=%h exp=%h", rdata, exp_rdata); end
    endtask

    task automatic test_clkdiv3();
        logic        s3 [1:250];
        logic [15:0] a;
        int          dcyc = -1, low = 0, fl = 0, blast = 0, bad = 0;
        a = 16'($urandom);
        pat3 = {8'($urandom), 32'($urandom)};
        @(negedge clk);
        op3 = 2'b01; sel3 = 1'b1; addr3 = a;
        @(posedge clk);
        for (int c = 1; c <= 250; c++) begin
            @(negedge clk);
            s3[c] = sclk3;
            if (done3 && dcyc < 0) dcyc = c;
            if (!csr3_n) low++;
            if (!csf3_n) fl++;
            if (busy3) blast = c;
            if (c == 242) op3 = 2'b00;
        end
        for (int c = 1; c <= 240; c++)
            if (s3[c] !== (((c - 1) % 6) >= 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL div3_sclk_shape bad_cycles=%0d exp=0", bad); end
        checks++; if (dcyc !== 241) begin errors++; $display("FAIL div3_done_cycle got=%0d exp=241", dcyc); end
        checks++; if (blast !== 241) begin errors++; $display("FAIL div3_idle got_busy_last=%0d exp=241", blast); end
        checks++; if (low !== 240 || fl !== 0) begin errors++; $display("FAIL div3_cs got=%0d/%0d exp=240/0", low, fl); end
        checks++; if (frame3 !== {16'h0300, a, 8'h00}) begin errors++; $display("FAIL div3_frame got=%h exp=%h", frame3, {16'h0300, a, 8'h00}); end
        checks++; if (rdata3 !== pat3[7:0]) begin errors++; $display("FAIL div3_data got=%h exp=%h", rdata3, pat3[7:0]); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            flash_mem[i] = 8'($urandom);
            ram_mem[i]   = 8'($urandom);
            ref_ram[i]   = ram_mem[i];
        end
        test_reset();
        test_flash_read();
        test_ram_write();
        test_flash_write_reject();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_clkdiv3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
